mips_fetch_unit: RTL
====================

Name: mips_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main control decoder in the single-cycle MIPS core.
- Holds the PC and fetches one instruction per step from a handshaked instruction memory.
- Presents opcode/funct/instruction fields to the decoder and datapath.
- Consumes the decoder's Jump/Branch/NEqual/Jr outputs plus ALU zero and rs data to select the next PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
clk        input   1   core clock, all state on rising edge
rst_n      input   1   asynchronous active-low reset
IM_req     output  1   instruction memory read request
IM_addr    output  32  instruction memory byte address (= pc)
IM_rdata   input   32  instruction word, valid when IM_ready=1
IM_ready   input   1   memory response strobe; meaningful only while IM_req=1
stall      input   1   datapath not ready to commit current instruction (e.g. data memory busy)
Jump       input   1   from decoder: j/jal
Branch     input   1   from decoder: beq/bne
NEqual     input   1   from decoder: 1=bne, 0=beq
Jr         input   1   from decoder: jr
zero       input   1   ALU zero flag for current instruction
rs_data    input   32  register-file rs read data (jr target)
instr      output  32  latched instruction word
opcode     output  6   instr[31:26]
funct      output  6   instr[5:0]
instr_valid output 1   instr is current and executing this cycle
pc         output  32  address of current instruction
pc_plus4   output  32  pc+4; jal link value

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, pc=RESET_PC, instr=32'h0, instr_valid=0, IM_req=0.
  - opcode/funct=0; pc_plus4=RESET_PC+4.
- States:
  - IDLE: single cycle after reset release; unconditionally -> FETCH.
  - FETCH: IM_req=1, IM_addr=pc, instr_valid=0.
    - IM_ready=0: stay; pc and instr held.
    - IM_ready=1: instr<=IM_rdata, -> EXEC.
  - EXEC: IM_req=0, instr_valid=1.
    - stall=1: stay; instr and pc held.
    - stall=0: pc<=next_pc, -> FETCH.
- Minimum per-instruction cost: 2 cycles (FETCH with immediate IM_ready, then EXEC).
  - First IM_req asserts 1 cycle after reset release.
  - instr_valid is high exactly one cycle per instruction when IM_ready and stall are both immediate.
- next_pc, combinational from latched instr and inputs, priority order:
  1. Jr=1: {rs_data[31:2],2'b00}; misaligned low bits silently cleared.
  2. Jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  3. Branch=1 and (zero XOR NEqual)=1: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  4. Otherwise: pc_plus4.
- Arithmetic:
  - All adds are 32-bit modulo 2^32; carry discarded.
  - pc=32'hFFFF_FFFC sequential -> 32'h0000_0000.
  - Negative branch offsets wrap likewise.
- Jump, Branch and Jr are sampled only in EXEC with stall=0; values in other states are ignored.
- IM_ready while IM_req=0 is ignored.
- IM_rdata is captured only on the FETCH+IM_ready cycle.
- Async reset mid-FETCH or mid-EXEC:
  - Abandons the transaction; the outstanding request is not retried.
  - The memory must tolerate IM_req dropping.
- opcode, funct and pc_plus4 are continuous functions of instr/pc, valid in every state.
  - The decoder must qualify its effect with instr_valid.

Test Plan:
- Reset then IM_ready=1 every FETCH cycle, memory returns add instructions -> IM_addr sequence 0,4,8,12; instr_valid pulses every 2nd cycle; first IM_req 1 cycle after rst_n rises.
- beq at pc=0x10, imm=16'hFFFC, Branch=1, NEqual=0, zero=1 -> next IM_addr=0x04. Same with zero=0 -> 0x14.
- bne at pc=0x20, imm=0x0003, Branch=1, NEqual=1, zero=0 -> 0x30.
- j at pc=0x4000_0000, instr[25:0]=0x0000100 -> IM_addr 0x4000_0400.
- jr with rs_data=0x0000_1237 and Jump=1 also asserted -> Jr wins, IM_addr 0x0000_1234.
- Handshake and reset:
  - IM_ready held low 3 cycles -> IM_req and IM_addr held, instr unchanged.
  - stall=1 in EXEC for 4 cycles -> instr_valid stays 1, pc unchanged.
  - rst_n pulsed low mid-FETCH -> outputs immediately at reset values, IM_req=0.
- Wrap: pc=0xFFFF_FFFC, sequential instruction -> next IM_addr 0x0000_0000.

Source files
------------

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches through a ready/req handshake
// and selects the next PC from the decoder's jump/branch controls.
module mips_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        IM_req,
   output logic [31:0] IM_addr,
   input  logic [31:0] IM_rdata,
   input  logic        IM_ready,
   input  logic        stall,
   input  logic        Jump,
   input  logic        Branch,
   input  logic        NEqual,
   input  logic        Jr,
   input  logic        zero,
   input  logic [31:0] rs_data,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } state_t;

   state_t state, state_next;

   logic            req_next;
   logic            valid_next;
   logic            capture;
   logic            advance;
   logic [XLEN-1:0] branch_off;
   logic [XLEN-1:0] next_pc;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    state_next = FETCH;
         FETCH:   if (IM_ready) state_next = EXEC;
         EXEC:    if (!stall)   state_next = FETCH;
         default: state_next = IDLE;
      endcase
   end

   // Output/strobe logic; req and valid are registered from the next state
   always_comb begin
      req_next   = (state_next == FETCH);
      valid_next = (state_next == EXEC);
      capture    = (state == FETCH) && IM_ready;
      advance    = (state == EXEC) && !stall;
   end

   // Next-PC select: jr > j > taken branch > sequential, all mod 2^32
   always_comb begin
      branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};
      if (Jr)
         next_pc = rs_data & 32'hFFFF_FFFC;
      else if (Jump)
         next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      else if (Branch && (zero ^ NEqual))
         next_pc = XLEN'(pc_plus4 + branch_off);
      else
         next_pc = pc_plus4;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         instr       <= '0;
         IM_req      <= 1'b0;
         instr_valid <= 1'b0;
      end else begin
         IM_req      <= req_next;
         instr_valid <= valid_next;
         if (capture) instr <= IM_rdata;
         if (advance) pc    <= next_pc;
      end
   end

   assign IM_addr  = pc;
   assign pc_plus4 = XLEN'(pc + 32'd4);
   assign opcode   = instr[31:26];
   assign funct    = instr[5:0];

endmodule
